// File: rtl/logic_gate_pipe_if.sv
// Operand-stream and result-stream signals of logic_gate_pipe.
// The slave modport is the gate unit's view; master is the source/consumer side.
interface logic_gate_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       mode;
    logic             acc_en;
    logic             acc_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_beats;
    logic             out_trunc;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, mode, acc_en, acc_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_trunc, busy
    );

    modport master (
        output in_valid, in_a, in_b, mode, acc_en, acc_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_trunc, busy
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Registered eight-function bitwise gate with optional burst folding (accumulate)
// and a one-deep valid/ready result register.
module logic_gate_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_gate_pipe_if.slave    bus
);
    typedef enum logic {StIdle, StAccum} state_t;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BEATS);

    state_t           r_state, w_state_d;
    logic [WIDTH-1:0] r_acc, w_acc_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [1:0]       r_op, w_op_d;
    logic             r_inv, w_inv_d;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_beats;
    logic             r_out_trunc;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic [CNT_W-1:0] w_load_beats;
    logic             w_load_trunc;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;

    function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (m)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Base op codes: 0 AND, 1 OR, 2 XOR; inversion applied only at termination.
    function automatic logic [WIDTH-1:0] fold_f(input logic [1:0] op,
                                                input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] a);
        case (op)
            2'd0:    return acc & a;
            2'd1:    return acc | a;
            default: return acc ^ a;
        endcase
    endfunction

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_acc_next = fold_f(r_op, r_acc, bus.in_a);
    assign w_cnt_next = r_cnt + 1'b1;

    always_comb begin
        w_state_d    = r_state;
        w_acc_d      = r_acc;
        w_cnt_d      = r_cnt;
        w_op_d       = r_op;
        w_inv_d      = r_inv;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_beats = CNT_W'(1);
        w_load_trunc = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (bus.acc_en && (bus.mode < 3'd6)) begin
                        w_inv_d = (bus.mode >= 3'd3);
                        case (bus.mode)
                            3'd0, 3'd3: w_op_d = 2'd0;
                            3'd1, 3'd4: w_op_d = 2'd1;
                            default:    w_op_d = 2'd2;
                        endcase
                        w_acc_d = bus.in_a;
                        w_cnt_d = CNT_W'(1);
                        if (bus.acc_last) begin
                            w_load      = 1'b1;
                            w_load_data = (bus.mode >= 3'd3) ? ~bus.in_a : bus.in_a;
                            w_cnt_d     = '0;
                        end else begin
                            w_state_d = StAccum;
                        end
                    end else begin
                        w_load      = 1'b1;
                        w_load_data = gate_f(bus.mode, bus.in_a, bus.in_b);
                    end
                end
            end
            StAccum: begin
                if (w_accept) begin
                    w_acc_d = w_acc_next;
                    w_cnt_d = w_cnt_next;
                    if (bus.acc_last || (w_cnt_next == MaxCnt)) begin
                        w_load       = 1'b1;
                        w_load_data  = r_inv ? ~w_acc_next : w_acc_next;
                        w_load_beats = w_cnt_next;
                        w_load_trunc = !bus.acc_last;
                        w_cnt_d      = '0;
                        w_state_d    = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
            r_op    <= w_op_d;
            r_inv   <= w_inv_d;
        end
    end

    // A new result may replace the one being transferred on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
            r_out_trunc <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_out_beats <= w_load_beats;
            r_out_trunc <= w_load_trunc;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_beats = r_out_beats;
    assign bus.out_trunc = r_out_trunc;
    assign bus.busy      = (r_state == StAccum);
endmodule
